game_scheduler: RTL
===================

GAME_SCHEDULER -- requirements
Module: game_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 833333, meaning clk cycles per frame tick (60 Hz at 50 MHz).
REQ-002 SHALL have parameter WD_LIMIT, default 65535, meaning the maximum clk cycles allowed in PHYS or DRAW before the watchdog fires.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port go, input, 1 bit: level request to start or restart a game.
REQ-006 SHALL have port grav_sw, input, 1 bit: raw gravity switch.
REQ-007 SHALL have port endgame, input, 1 bit: datapath game-over flag, sampled in PHYS.
REQ-008 SHALL have port phys_done, input, 1 bit: datapath physics step complete.
REQ-009 SHALL have port draw_done, input, 1 bit: screen updater frame complete.
REQ-010 SHALL have port menu / physics / setup / display, output, 1 bit each: one-hot phase enables to datapath and screen updater.
REQ-011 SHALL have port phys_start / draw_start, output, 1 bit each: single-cycle start pulses.
REQ-012 SHALL have port grav, output, 1 bit: gravity latched once per frame.
REQ-013 SHALL have port frame_cnt, output, 8 bits: completed-frame count, wraps 255->0.
REQ-014 SHALL have port state, output, 3 bits: encoded current state for HEX debug.
REQ-015 SHALL have port wd_err, output, 1 bit: sticky watchdog error.

Function
REQ-016 SHALL implement states MENU=0, WAIT_TICK=1, PHYS=2, SETUP=3, DRAW=4, OVER=5; state SHALL equal the current encoding.
REQ-017 SHALL run a tick counter 0..TICK_DIV-1, free-running in all states; tick is asserted for one cycle when the count wraps.
REQ-018 MENU: menu=1; go=1 SHALL move to WAIT_TICK, clear frame_cnt and clear wd_err.
REQ-019 WAIT_TICK: on tick, SHALL latch grav<=grav_sw, pulse phys_start in the same cycle, and enter PHYS.
REQ-020 PHYS: physics=1; on phys_done with endgame=1 SHALL go to OVER; on phys_done with endgame=0 SHALL go to SETUP.
REQ-021 SETUP: setup=1 for exactly one cycle, then SHALL pulse draw_start and enter DRAW.
REQ-022 DRAW: display=1; on draw_done SHALL increment frame_cnt (mod 256) and return to WAIT_TICK.
REQ-023 OVER: all phase enables are 0; go SHALL be ignored until it is seen low for at least one cycle, after which a subsequent go=1 SHALL enter MENU.
REQ-024 A tick arriving outside WAIT_TICK SHALL be dropped, not queued; frames overrunning their tick skip to the next tick.
REQ-025 done inputs asserted outside their own state SHALL be ignored.
REQ-026 phys_start and draw_start SHALL never be high in the same cycle and SHALL never last more than one cycle.
REQ-027 grav SHALL be constant from the PHYS entry through the end of DRAW, regardless of grav_sw.
REQ-028 Exactly one of menu/physics/setup/display SHALL be high in MENU, PHYS, SETUP and DRAW; none SHALL be high in WAIT_TICK or OVER.

Reset
REQ-029 While reset=1, the block SHALL asynchronously hold: state=MENU, menu=1, other enables=0, start pulses=0, grav=0, frame_cnt=0, wd_err=0, tick counter=0.
REQ-030 Reset asserted mid-PHYS or mid-DRAW SHALL abort without emitting any further pulse; the first state after release SHALL be MENU.

Configuration
REQ-031 With GAME_SCHEDULER_WATCHDOG_EN defined, a per-state cycle counter SHALL run in PHYS and DRAW; reaching WD_LIMIT without the matching done SHALL set wd_err=1 and force OVER.
REQ-032 Without GAME_SCHEDULER_WATCHDOG_EN, there SHALL be no watchdog counter, wd_err SHALL be tied to 0, and PHYS/DRAW SHALL wait indefinitely.

Verification
REQ-033 TICK_DIV=10; reset, then go=1, with phys_done and draw_done each 3 cycles after their start -> phys_start every 10 cycles, and frame_cnt=1, 2, 3 after the first three ticks.
REQ-034 grav_sw toggled 2 cycles after phys_start -> grav unchanged until the next phys_start, then takes the new value.
REQ-035 phys_done with endgame=1 -> OVER, state=5, all enables 0; go held high -> stays in OVER; go low then high -> MENU.
REQ-036 draw_done delayed 15 cycles with TICK_DIV=10 -> one tick dropped, next phys_start 20 cycles after the previous one, no double pulse.
REQ-037 reset pulsed for 1 cycle mid-DRAW -> outputs at reset values immediately (asynchronously), and state=0 after release.
REQ-038 Watchdog enabled, WD_LIMIT=50, phys_done never asserted -> wd_err=1 and state=5 exactly 50 cycles after PHYS entry; with the macro undefined, still in PHYS after 1000 cycles.

Source files
------------

// File: rtl/game_scheduler.sv
// game_scheduler: frame sequencer MENU -> WAIT_TICK -> PHYS -> SETUP -> DRAW, with a game-over hold.
// Optional PHYS/DRAW watchdog is compiled in when GAME_SCHEDULER_WATCHDOG_EN is defined.
module game_scheduler #(
    parameter int TICK_DIV = 833333,
    parameter int WD_LIMIT = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       grav_sw,
    input  logic       endgame,
    input  logic       phys_done,
    input  logic       draw_done,
    output logic       menu,
    output logic       physics,
    output logic       setup,
    output logic       display,
    output logic       phys_start,
    output logic       draw_start,
    output logic       grav,
    output logic [7:0] frame_cnt,
    output logic [2:0] state,
    output logic       wd_err
);

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        WAIT_TICK = 3'd1,
        PHYS      = 3'd2,
        SETUP     = 3'd3,
        DRAW      = 3'd4,
        OVER      = 3'd5
    } state_t;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t        cur_st;
    state_t        nxt_st;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          clr_game;
    logic          frame_inc;
    logic          wd_fire;
    logic          go_low_seen;

    assign state = cur_st;
    assign tick  = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur_st <= MENU;
        else       cur_st <= nxt_st;
    end

    // Handshake: *_start is a one-cycle request issued on the cycle the FSM commits to the
    // phase; the matching *_done is honoured only while in that phase and ends it that cycle.
    always_comb begin
        nxt_st     = cur_st;
        menu       = 1'b0;
        physics    = 1'b0;
        setup      = 1'b0;
        display    = 1'b0;
        phys_start = 1'b0;
        draw_start = 1'b0;
        clr_game   = 1'b0;
        frame_inc  = 1'b0;
        case (cur_st)
            MENU: begin
                menu = 1'b1;
                if (go) begin
                    clr_game = 1'b1;
                    nxt_st   = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (tick) begin
                    phys_start = 1'b1;
                    nxt_st     = PHYS;
                end
            end
            PHYS: begin
                physics = 1'b1;
                if (phys_done)    nxt_st = endgame ? OVER : SETUP;
                else if (wd_fire) nxt_st = OVER;
            end
            SETUP: begin
                setup      = 1'b1;
                draw_start = 1'b1;
                nxt_st     = DRAW;
            end
            DRAW: begin
                display = 1'b1;
                if (draw_done) begin
                    frame_inc = 1'b1;
                    nxt_st    = WAIT_TICK;
                end else if (wd_fire) begin
                    nxt_st = OVER;
                end
            end
            OVER: begin
                if (go && go_low_seen) nxt_st = MENU;
            end
            default: nxt_st = MENU;
        endcase
    end

    // go_low_seen arms only inside OVER so a go held from before game-over cannot restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grav        <= 1'b0;
            frame_cnt   <= '0;
            go_low_seen <= 1'b0;
        end else begin
            if (phys_start) grav <= grav_sw;
            if (clr_game)       frame_cnt <= '0;
            else if (frame_inc) frame_cnt <= frame_cnt + 8'd1;
            go_low_seen <= (cur_st == OVER) && (go_low_seen || !go);
        end
    end

`ifdef GAME_SCHEDULER_WATCHDOG_EN
    localparam int WW = $clog2(WD_LIMIT + 1);

    logic [WW-1:0] wd_cnt;
    logic          wd_err_q;

    assign wd_fire = ((cur_st == PHYS && !phys_done) || (cur_st == DRAW && !draw_done))
                     && (wd_cnt == WW'(WD_LIMIT - 1));
    assign wd_err  = wd_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt   <= '0;
            wd_err_q <= 1'b0;
        end else begin
            if (cur_st == PHYS || cur_st == DRAW) wd_cnt <= wd_cnt + WW'(1);
            else                                  wd_cnt <= '0;
            if (clr_game)     wd_err_q <= 1'b0;
            else if (wd_fire) wd_err_q <= 1'b1;
        end
    end
`else
    logic wd_unused;

    assign wd_unused = ^WD_LIMIT;
    assign wd_fire   = 1'b0;
    assign wd_err    = 1'b0;
`endif

endmodule
